// File: rtl/aes_pkg.sv
// Shared AES types and byte-level helpers for the iterative cipher core.
// The state is held column-major, with byte 0 in the most significant position.
package aes_pkg;

    localparam int unsigned NR_AES128 = 10;
    localparam int unsigned NR_AES192 = 12;
    localparam int unsigned NR_AES256 = 14;

    typedef logic [0:3][7:0]       aes_col_t;
    // Indexed [col][row]; [0][0] is bits 127:120.
    typedef logic [0:3][0:3][7:0]  aes_state_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic aes_col_t mix_column(input aes_col_t c);
        aes_col_t m;
        m[0] = xtime(c[0]) ^ xtime(c[1]) ^ c[1] ^ c[2] ^ c[3];
        m[1] = xtime(c[1]) ^ xtime(c[2]) ^ c[2] ^ c[3] ^ c[0];
        m[2] = xtime(c[2]) ^ xtime(c[3]) ^ c[3] ^ c[0] ^ c[1];
        m[3] = xtime(c[3]) ^ xtime(c[0]) ^ c[0] ^ c[1] ^ c[2];
        return m;
    endfunction

    function automatic aes_state_t shift_rows(input aes_state_t s);
        aes_state_t o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[2'(c)][2'(r)] = s[2'(c + r)][2'(r)];
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box as a 256-entry lookup.
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/aes256_cipher_core.sv
// Iterative AES encryption core, one round per clock, valid/ready on both sides.
// Define AES_KEY_LATCH_EN to capture round keys 1..NR at accept instead of reading them live.
module aes256_cipher_core
    import aes_pkg::*;
#(
    parameter int unsigned NR = NR_AES256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [127:0]         plaintext,
    input  logic [NR:0][127:0]   round_key,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [127:0]         ciphertext
);

    if (!(NR == NR_AES128 || NR == NR_AES192 || NR == NR_AES256)) begin : g_bad_nr
        $error("aes256_cipher_core: NR must be 10, 12 or 14");
    end

    fsm_state_t  r_fsm, w_fsm_d;
    logic [3:0]  r_ctr, w_ctr_d;
    aes_state_t  r_blk, w_blk_d;
    aes_state_t  w_sub, w_shift, w_mix, w_next;
    logic [127:0] w_rk;
    logic        w_accept;

    for (genvar gi = 0; gi < 16; gi++) begin : g_sbox
        aes_sbox u_sbox (
            .i_byte (r_blk[gi / 4][gi % 4]),
            .o_byte (w_sub[gi / 4][gi % 4])
        );
    end

    assign w_shift = shift_rows(w_sub);

    for (genvar gc = 0; gc < 4; gc++) begin : g_mix
        assign w_mix[gc] = mix_column(w_shift[gc]);
    end

`ifdef AES_KEY_LATCH_EN
    logic [NR:1][127:0] r_keys;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_keys <= round_key[NR:1];
        end
    end

    assign w_rk = r_keys[r_ctr];
`else
    // Upstream holds round_key stable for the whole block.
    assign w_rk = round_key[r_ctr];
`endif

    // Final round skips MixColumns.
    assign w_next = (r_ctr == 4'(NR)) ? (w_shift ^ w_rk) : (w_mix ^ w_rk);

    always_comb begin
        w_fsm_d  = r_fsm;
        w_ctr_d  = r_ctr;
        w_blk_d  = r_blk;
        in_ready = (r_fsm == IDLE) || ((r_fsm == DONE) && out_ready);
        w_accept = in_valid && in_ready;
        case (r_fsm)
            RUN: begin
                w_blk_d = w_next;
                if (r_ctr == 4'(NR)) begin
                    w_fsm_d = DONE;
                end else begin
                    w_ctr_d = r_ctr + 4'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_fsm_d = IDLE;
                    w_ctr_d = 4'd0;
                end
            end
            default: ;
        endcase
        // An accept in DONE overrides the return to IDLE.
        if (w_accept) begin
            w_blk_d = plaintext ^ round_key[0];
            w_ctr_d = 4'd1;
            w_fsm_d = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fsm <= IDLE;
            r_ctr <= 4'd0;
            r_blk <= '0;
        end else begin
            r_fsm <= w_fsm_d;
            r_ctr <= w_ctr_d;
            r_blk <= w_blk_d;
        end
    end

    assign out_valid  = (r_fsm == DONE);
    assign ciphertext = out_valid ? r_blk : '0;

endmodule

// File: tb/tb_aes256_cipher_core.sv
// Directed bench for aes256_cipher_core with a ciphertext scoreboard and a key-expansion model.
// Covers the key-change-after-accept case when AES_KEY_LATCH_EN is defined.
module tb_aes256_cipher_core;

    localparam logic [255:0] KEY_C3 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY_ALT = {8{32'h12345678}};
    localparam logic [127:0] PT_C3 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] CT_Z  = 128'hdc95c078a2408989ad48a21492842087;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [127:0]        plaintext = '0;
    logic [14:0][127:0]  round_key = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [127:0]        ciphertext;

    logic [7:0]   sb [256];
    logic [127:0] exp_q [$];
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    aes256_cipher_core dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .round_key  (round_key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext)
    );

    initial begin
        #200000;
        $display("FAIL watchdog observed no_finish required finish");
        $fatal(1, "timeout");
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
    endfunction

    function automatic logic [14:0][127:0] expand(input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        logic [14:0][127:0] rk;
        for (int i = 0; i < 8; i++) w[i] = key[255 - 32 * i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i - 1];
            if (i % 8 == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                t = subw(t);
            end
            w[i] = w[i - 8] ^ t;
        end
        for (int r = 0; r < 15; r++) rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
        return rk;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag);
        logic [127:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        chk(tag, ciphertext, e);
    endtask

    // Counts the accept edge as cycle 1; stops when out_valid is seen or the budget runs out.
    task automatic wait_out(output int cyc);
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        int seen;
        logic [127:0] held;

        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end

        tick();
        tick();
        rst = 1'b1;
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_ciphertext", ciphertext, 128'd0);

        // FIPS-197 C.3 with latency check
        round_key = expand(KEY_C3);
        plaintext = PT_C3;
        in_valid  = 1'b1;
        exp_q.push_back(CT_C3);
        tick();
        in_valid = 1'b0;
        wait_out(cyc);
        chk("c3_latency", 128'(cyc), 128'd15);
        out_ready = 1'b1;
        chk_out("c3_ciphertext");
        tick();
        chk("c3_valid_drop", 128'(out_valid), 128'd0);
        chk("c3_in_ready", 128'(in_ready), 128'd1);

        // All-zero key and plaintext, held under backpressure for 10 cycles
        out_ready = 1'b0;
        round_key = expand(256'd0);
        plaintext = '0;
        in_valid  = 1'b1;
        exp_q.push_back(CT_Z);
        tick();
        in_valid = 1'b0;
        wait_out(cyc);
        chk("zero_latency", 128'(cyc), 128'd15);
        held = ciphertext;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_out_valid", 128'(out_valid), 128'd1);
            chk("bp_in_ready", 128'(in_ready), 128'd0);
            chk("bp_held", ciphertext, held);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 128'(in_ready), 128'd1);
        chk_out("zero_ciphertext");
        tick();
        chk("bp_valid_drop", 128'(out_valid), 128'd0);

        // Back-to-back; plaintext scrambled while RUN must be ignored
        round_key = expand(KEY_C3);
        plaintext = PT_C3;
        in_valid  = 1'b1;
        exp_q.push_back(CT_C3);
        tick();
        plaintext = {$urandom, $urandom, $urandom, $urandom};
        wait_out(cyc);
        chk("b2b_first_latency", 128'(cyc), 128'd15);
        chk("b2b_in_ready", 128'(in_ready), 128'd1);
        chk_out("b2b_first_ct");
        plaintext = PT_C3;
        exp_q.push_back(CT_C3);
        tick();
        in_valid = 1'b0;
        chk("b2b_second_accepted", 128'(out_valid), 128'd0);
        chk("b2b_busy", 128'(in_ready), 128'd0);
        wait_out(cyc);
        chk("b2b_second_latency", 128'(cyc), 128'd15);
        chk_out("b2b_second_ct");
        tick();
        chk("b2b_valid_drop", 128'(out_valid), 128'd0);

        // Reset at round 7 discards the block
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("midrst_out_valid", 128'(out_valid), 128'd0);
        chk("midrst_in_ready", 128'(in_ready), 128'd1);
        chk("midrst_ciphertext", ciphertext, 128'd0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid === 1'b1) seen++;
        end
        chk("midrst_no_output", 128'(seen), 128'd0);
        in_valid = 1'b1;
        exp_q.push_back(CT_C3);
        tick();
        in_valid = 1'b0;
        wait_out(cyc);
        chk("postrst_latency", 128'(cyc), 128'd15);
        chk_out("postrst_ct");
        tick();

`ifdef AES_KEY_LATCH_EN
        in_valid = 1'b1;
        exp_q.push_back(CT_C3);
        tick();
        in_valid = 1'b0;
        tick();
        round_key = expand(KEY_ALT);
        wait_out(cyc);
        chk("latch_latency", 128'(cyc), 128'd15);
        chk_out("latch_ct");
        tick();
        round_key = expand(KEY_C3);
`endif

        chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
